// File: rtl/butterfly12.sv
// butterfly12: two-stage radix-2 butterfly over 4-beat frames of NUM complex lanes.
// Define BUTTERFLY12_SAT_EN to saturate the (181-181j)/256 twiddle path instead of wrapping.
module butterfly12 #(
    parameter int IN_WIDTH  = 15,
    parameter int OUT_WIDTH = IN_WIDTH + 1,
    parameter int NUM       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  din_re [0:NUM-1],
    input  logic signed [IN_WIDTH-1:0]  din_im [0:NUM-1],
    input  logic                        valid_in,
    output logic signed [OUT_WIDTH-1:0] do_re [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] do_im [0:NUM-1],
    output logic                        valid_out,
    output logic                        sop_out
);
    localparam int DW = IN_WIDTH + 1;
    localparam int PW = (DW + 10 > OUT_WIDTH + 1) ? DW + 10 : OUT_WIDTH + 1;
    localparam logic signed [PW-1:0] K181 = PW'(32'sd181);
    localparam logic signed [PW-1:0] HALF_LSB = PW'(32'sd128);
`ifdef BUTTERFLY12_SAT_EN
    localparam logic signed [PW-1:0] OMAX = PW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] OMIN = ~OMAX;
`endif

    logic        [1:0]           bcnt_q, bcnt_d;
    logic                        pend_q, pend_d;
    logic                        rd_q, rd_d;
    logic signed [IN_WIDTH-1:0]  hold_re_q [0:1][0:NUM-1];
    logic signed [IN_WIDTH-1:0]  hold_im_q [0:1][0:NUM-1];
    logic signed [IN_WIDTH-1:0]  hold_re_d [0:1][0:NUM-1];
    logic signed [IN_WIDTH-1:0]  hold_im_d [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] dbuf_re_q [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] dbuf_im_q [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] dbuf_re_d [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] dbuf_im_d [0:1][0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do_re_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do_im_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do_re_d [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do_im_d [0:NUM-1];
    logic                        valid_q, valid_d;
    logic                        sop_q, sop_d;

    logic signed [DW-1:0]        diff_re [0:NUM-1];
    logic signed [DW-1:0]        diff_im [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] sum_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] sum_im [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] tw_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] tw_im [0:NUM-1];

    // Multiply by 181/256 with symmetric round-half-away-from-zero, then saturate or wrap.
    function automatic logic signed [OUT_WIDTH-1:0] t3_scale(input logic signed [DW:0] s);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] mag;
        logic signed [PW-1:0] rnd;
        logic signed [PW-1:0] res;
        prod = PW'(s) * K181;
        mag  = prod[PW-1] ? -prod : prod;
        rnd  = (mag + HALF_LSB) >>> 8;
        res  = prod[PW-1] ? -rnd : rnd;
`ifdef BUTTERFLY12_SAT_EN
        if (res > OMAX) begin
            t3_scale = OUT_WIDTH'(OMAX);
        end else if (res < OMIN) begin
            t3_scale = OUT_WIDTH'(OMIN);
        end else begin
            t3_scale = OUT_WIDTH'(res);
        end
`else
        t3_scale = OUT_WIDTH'(res);
`endif
    endfunction

    // Lane arithmetic for beats 2/3: exact sum, and diff rotated by twiddle index {j, upper half}.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            sum_re[i]  = OUT_WIDTH'(DW'(hold_re_q[bcnt_q[0]][i]) + DW'(din_re[i]));
            sum_im[i]  = OUT_WIDTH'(DW'(hold_im_q[bcnt_q[0]][i]) + DW'(din_im[i]));
            diff_re[i] = DW'(hold_re_q[bcnt_q[0]][i]) - DW'(din_re[i]);
            diff_im[i] = DW'(hold_im_q[bcnt_q[0]][i]) - DW'(din_im[i]);
            case ({bcnt_q[0], (i >= NUM / 2) ? 1'b1 : 1'b0})
                2'b10: begin
                    tw_re[i] = OUT_WIDTH'(diff_im[i]);
                    tw_im[i] = OUT_WIDTH'(-diff_re[i]);
                end
                2'b11: begin
                    tw_re[i] = t3_scale((DW + 1)'(diff_re[i]) + (DW + 1)'(diff_im[i]));
                    tw_im[i] = t3_scale((DW + 1)'(diff_im[i]) - (DW + 1)'(diff_re[i]));
                end
                default: begin
                    tw_re[i] = OUT_WIDTH'(diff_re[i]);
                    tw_im[i] = OUT_WIDTH'(diff_im[i]);
                end
            endcase
        end
    end

    // Next state: beat counting, hold/dbuf capture, and output selection (drain vs. sum).
    always_comb begin
        bcnt_d    = bcnt_q;
        pend_d    = pend_q;
        rd_d      = rd_q;
        hold_re_d = hold_re_q;
        hold_im_d = hold_im_q;
        dbuf_re_d = dbuf_re_q;
        dbuf_im_d = dbuf_im_q;
        do_re_d   = do_re_q;
        do_im_d   = do_im_q;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        if (pend_q) begin
            for (int i = 0; i < NUM; i++) begin
                do_re_d[i] = dbuf_re_q[rd_q][i];
                do_im_d[i] = dbuf_im_q[rd_q][i];
            end
            valid_d = 1'b1;
            rd_d    = ~rd_q;
            pend_d  = ~rd_q;
        end else begin
            rd_d = rd_q;
        end
        // A drain never overlaps beats 2/3, so the sum path can share the output register.
        if (valid_in) begin
            bcnt_d = bcnt_q + 2'd1;
            if (!bcnt_q[1]) begin
                for (int i = 0; i < NUM; i++) begin
                    hold_re_d[bcnt_q[0]][i] = din_re[i];
                    hold_im_d[bcnt_q[0]][i] = din_im[i];
                end
            end else begin
                for (int i = 0; i < NUM; i++) begin
                    do_re_d[i]              = sum_re[i];
                    do_im_d[i]              = sum_im[i];
                    dbuf_re_d[bcnt_q[0]][i] = tw_re[i];
                    dbuf_im_d[bcnt_q[0]][i] = tw_im[i];
                end
                valid_d = 1'b1;
                sop_d   = ~bcnt_q[0];
                pend_d  = pend_d | bcnt_q[0];
                rd_d    = bcnt_q[0] ? 1'b0 : rd_d;
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= 2'd0;
            pend_q  <= 1'b0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                do_re_q[i] <= '0;
                do_im_q[i] <= '0;
                for (int b = 0; b < 2; b++) begin
                    hold_re_q[b][i] <= '0;
                    hold_im_q[b][i] <= '0;
                    dbuf_re_q[b][i] <= '0;
                    dbuf_im_q[b][i] <= '0;
                end
            end
        end else begin
            bcnt_q    <= bcnt_d;
            pend_q    <= pend_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
            hold_re_q <= hold_re_d;
            hold_im_q <= hold_im_d;
            dbuf_re_q <= dbuf_re_d;
            dbuf_im_q <= dbuf_im_d;
        end
    end

    assign do_re     = do_re_q;
    assign do_im     = do_im_q;
    assign valid_out = valid_q;
    assign sop_out   = sop_q;

endmodule
